// File: rtl/risc_v_fetch_pkg.sv
// Shared constants, the fetch-entry type and a saturating-add helper for the
// instruction-fetch controller.
package risc_v_fetch_pkg;

    localparam int unsigned PC_STEP  = 4;
    localparam logic [31:0] RST_PC   = 32'h0040_0000;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // One buffered fetch: the PC it was fetched from and the returned word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Add inc to val, clamping at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] inc);
        logic [32:0] sum;
        sum = {1'b0, val} + {1'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/risc_v_fetch_ctrl_fifo.sv
// fetch_fifo: synchronous FIFO with flush and occupancy count. Flush empties
// the FIFO and wins over a same-cycle push or pop. Pushes into a full FIFO and
// pops from an empty one are ignored. DEPTH must be a power of two.
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Pointer/count next state; flush empties everything.
    always_comb begin
        push_ok_s = push_i && (count_q != CNT_W'(DEPTH));
        pop_ok_s  = pop_i && (count_q != {CNT_W{1'b0}});
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_ok_s && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/risc_v_fetch_ctrl.sv
// risc_v_fetch_ctrl: instruction-fetch controller between the PC register and
// the IF/ID register. Issues memory reads under a credit limit, tags each
// request with its PC, buffers returned words and discards responses made
// stale by a redirect.
// Optional build macro FETCH_PERF_CNT_EN adds stall/flush performance counters.
module risc_v_fetch_ctrl
    import risc_v_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    output logic [ADDR_WIDTH-1:0] o_pc_next,
    output logic                  o_pc_en,
    output logic                  o_imem_req_valid,
    input  logic                  i_imem_req_ready,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    input  logic                  i_imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] i_imem_rsp_data,
    input  logic                  i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic                  o_inst_valid,
    input  logic                  i_inst_ready,
    output logic [DATA_WIDTH-1:0] o_inst,
    output logic [ADDR_WIDTH-1:0] o_inst_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           o_perf_stall_cnt,
    output logic [31:0]           o_perf_flush_cnt
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    // Outstanding requests equal the PC-tag queue occupancy: a tag is pushed
    // on acceptance and popped on every response, dropped or not.
    logic [CNT_W-1:0]      out_cnt_s;
    logic [CNT_W-1:0]      inst_cnt_s;
    logic [CNT_W-1:0]      drop_q, drop_d;
    logic [CNT_W:0]        occupancy_s;
    logic [ADDR_WIDTH-1:0] tag_head_s;
    logic [ENT_W-1:0]      inst_head_s;
    logic                  credit_ok_s;
    logic                  accept_s;
    logic                  rsp_keep_s;
    logic                  head_valid_s;
    logic                  inst_pop_s;

    // Request, PC-register, queue-control and drop-count decisions.
    always_comb begin
        occupancy_s      = {1'b0, out_cnt_s} + {1'b0, inst_cnt_s};
        credit_ok_s      = occupancy_s < DEPTH_LIM;
        o_imem_req_valid = !i_rst && !i_redirect_valid && credit_ok_s;
        o_imem_addr      = i_pc;
        accept_s         = o_imem_req_valid && i_imem_req_ready;
        o_pc_en          = !i_rst && (i_redirect_valid || accept_s);
        if (i_redirect_valid) begin
            o_pc_next = i_redirect_pc & ALIGN_MASK;
        end else begin
            o_pc_next = i_pc + ADDR_WIDTH'(PC_STEP);
        end
        rsp_keep_s   = i_imem_rsp_valid && !i_redirect_valid && (drop_q == {CNT_W{1'b0}});
        head_valid_s = inst_cnt_s != {CNT_W{1'b0}};
        inst_pop_s   = head_valid_s && i_inst_ready && !i_redirect_valid;
        o_inst_valid = head_valid_s;
        if (head_valid_s) begin
            o_inst_pc = inst_head_s[ENT_W-1:DATA_WIDTH];
            o_inst    = inst_head_s[DATA_WIDTH-1:0];
        end else begin
            o_inst_pc = {ADDR_WIDTH{1'b0}};
            o_inst    = {DATA_WIDTH{1'b0}};
        end
        // A redirect makes everything still in flight stale, including any
        // response arriving in the redirect cycle itself.
        if (i_redirect_valid) begin
            drop_d = out_cnt_s - CNT_W'(i_imem_rsp_valid);
        end else if (i_imem_rsp_valid && (drop_q != {CNT_W{1'b0}})) begin
            drop_d = drop_q - CNT_W'(1);
        end else begin
            drop_d = drop_q;
        end
    end

    // Count of responses still to be discarded.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_q <= {CNT_W{1'b0}};
        end else begin
            drop_q <= drop_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .flush_i (1'b0),
        .push_i  (accept_s),
        .data_i  (i_pc),
        .pop_i   (i_imem_rsp_valid),
        .data_o  (tag_head_s),
        .count_o (out_cnt_s)
    );

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .flush_i (i_redirect_valid),
        .push_i  (rsp_keep_s),
        .data_i  ({tag_head_s, i_imem_rsp_data}),
        .pop_i   (inst_pop_s),
        .data_o  (inst_head_s),
        .count_o (inst_cnt_s)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_inc_s;
    logic        stall_s;

    // Per-cycle increments for the performance counters.
    always_comb begin
        stall_s = !credit_ok_s && !i_redirect_valid;
        if (i_redirect_valid) begin
            flush_inc_s = 32'(i_imem_rsp_valid) + 32'(inst_cnt_s);
        end else begin
            flush_inc_s = 32'(i_imem_rsp_valid && (drop_q != {CNT_W{1'b0}}));
        end
    end

    // Saturating stall and flush counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= sat_inc(stall_cnt_q, {31'd0, stall_s});
            flush_cnt_q <= sat_inc(flush_cnt_q, flush_inc_s);
        end
    end

    assign o_perf_stall_cnt = stall_cnt_q;
    assign o_perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_risc_v_fetch_ctrl.sv
// Scoreboard bench for risc_v_fetch_ctrl. The bench models the PC register
// and an in-order instruction memory; each accepted fetch pushes its expected
// {pc, inst} into a scoreboard, a redirect or reset empties it, and a monitor
// compares every instruction handed to decode against the scoreboard head.
module tb_risc_v_fetch_ctrl;
    import risc_v_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_pc;
    logic [31:0] o_pc_next;
    logic        o_pc_en;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] o_perf_stall_cnt;
    logic [31:0] o_perf_flush_cnt;
`endif

    int           n_checks = 0;
    int           n_fail   = 0;
    logic         rsp_en;
    logic [31:0]  mem_q[$];
    fetch_entry_t sb_q[$];
    fetch_entry_t exp_e;

    always #5 clk = ~clk;

    risc_v_fetch_ctrl dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .i_pc             (i_pc),
        .o_pc_next        (o_pc_next),
        .o_pc_en          (o_pc_en),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_inst_valid     (o_inst_valid),
        .i_inst_ready     (i_inst_ready),
        .o_inst           (o_inst),
        .o_inst_pc        (o_inst_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_perf_stall_cnt (o_perf_stall_cnt),
        .o_perf_flush_cnt (o_perf_flush_cnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // One clock: sample at negedge, then update PC register and memory model.
    task automatic step();
        logic        acc;
        logic        en;
        logic        redir;
        logic [31:0] nxt;
        logic [31:0] addr;
        logic [31:0] a;
        @(negedge clk);
        acc   = o_imem_req_valid && i_imem_req_ready;
        en    = o_pc_en;
        nxt   = o_pc_next;
        addr  = o_imem_addr;
        redir = i_redirect_valid;
        @(posedge clk);
        #1;
        if (i_rst) begin
            i_pc = RST_PC;
            mem_q.delete();
            sb_q.delete();
            i_imem_rsp_valid = 1'b0;
            i_imem_rsp_data  = 32'd0;
        end else begin
            if (en) i_pc = nxt;
            if (redir) sb_q.delete();
            if (acc) begin
                mem_q.push_back(addr);
                sb_q.push_back('{pc: addr, inst: mem_word(addr)});
            end
            if (rsp_en && mem_q.size() > 0) begin
                a = mem_q.pop_front();
                i_imem_rsp_valid = 1'b1;
                i_imem_rsp_data  = mem_word(a);
            end else begin
                i_imem_rsp_valid = 1'b0;
                i_imem_rsp_data  = 32'd0;
            end
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        rsp_en = 1'b0;
        i_imem_req_ready = 1'b0;
        i_inst_ready = 1'b0;
        i_redirect_valid = 1'b0;
        repeat (2) step();
        chk("rst_inst_valid", {31'd0, o_inst_valid}, 32'd0);
        chk("rst_inst", o_inst, 32'd0);
        chk("rst_inst_pc", o_inst_pc, 32'd0);
        chk("rst_req_valid", {31'd0, o_imem_req_valid}, 32'd0);
        chk("rst_pc_en", {31'd0, o_pc_en}, 32'd0);
        i_rst = 1'b0;
    endtask

    task automatic drain(input string name);
        i_imem_req_ready = 1'b0;
        rsp_en = 1'b1;
        i_inst_ready = 1'b1;
        repeat (5) step();
        chk(name, sb_q.size(), 32'd0);
    endtask

    // Monitor: every instruction taken by decode must match the scoreboard head.
    always @(negedge clk) begin
        if (!i_rst && o_inst_valid && i_inst_ready && !i_redirect_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: actual pc %h required no instruction", o_inst_pc);
            end else begin
                exp_e = sb_q.pop_front();
                chk("sb_inst_pc", o_inst_pc, exp_e.pc);
                chk("sb_inst", o_inst, exp_e.inst);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1;
        i_pc = RST_PC;
        i_imem_req_ready = 1'b0;
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data = 32'd0;
        i_redirect_valid = 1'b0;
        i_redirect_pc = 32'd0;
        i_inst_ready = 1'b0;
        rsp_en = 1'b0;

        // Memory stall, then streaming, then a wrap at the top of the space.
        do_reset();
        rsp_en = 1'b1;
        i_inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_pc_en", {31'd0, o_pc_en}, 32'd0);
            chk("stall_addr", o_imem_addr, 32'h0040_0000);
            chk("stall_req_valid", {31'd0, o_imem_req_valid}, 32'd1);
            step();
        end
        i_imem_req_ready = 1'b1;
        #1;
        chk("stream_pc_en", {31'd0, o_pc_en}, 32'd1);
        chk("stream_pc_next", o_pc_next, 32'h0040_0004);
        repeat (12) step();
        drain("stream_drain");
        i_redirect_valid = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFE;
        #1;
        chk("wrap_redir_next", o_pc_next, 32'hFFFF_FFFC);
        chk("wrap_redir_req", {31'd0, o_imem_req_valid}, 32'd0);
        step();
        i_redirect_valid = 1'b0;
        i_imem_req_ready = 1'b1;
        #1;
        chk("wrap_addr", o_imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc_en", {31'd0, o_pc_en}, 32'd1);
        chk("wrap_pc_next", o_pc_next, 32'h0000_0000);
        step();
        drain("wrap_drain");

        // Back-pressure: decode stalled, two fetches fill the credit.
        do_reset();
        i_imem_req_ready = 1'b1;
        rsp_en = 1'b1;
        step();
        step();
        #1;
        chk("bp_req_c", {31'd0, o_imem_req_valid}, 32'd0);
        chk("bp_pc_en_c", {31'd0, o_pc_en}, 32'd0);
        step();
        #1;
        chk("bp_req_d", {31'd0, o_imem_req_valid}, 32'd0);
        chk("bp_pc_en_d", {31'd0, o_pc_en}, 32'd0);
        chk("bp_head_valid", {31'd0, o_inst_valid}, 32'd1);
        chk("bp_head_pc", o_inst_pc, 32'h0040_0000);
        i_inst_ready = 1'b1;
        repeat (8) step();
        drain("bp_drain");

        // Redirect with two requests outstanding: both responses dropped.
        do_reset();
        i_imem_req_ready = 1'b1;
        i_inst_ready = 1'b1;
        step();
        step();
        #1;
        chk("rd_req_full", {31'd0, o_imem_req_valid}, 32'd0);
        chk("rd_pc_en_full", {31'd0, o_pc_en}, 32'd0);
        i_redirect_valid = 1'b1;
        i_redirect_pc = 32'h0040_0103;
        #1;
        chk("rd_pc_next", o_pc_next, 32'h0040_0100);
        chk("rd_pc_en", {31'd0, o_pc_en}, 32'd1);
        chk("rd_req", {31'd0, o_imem_req_valid}, 32'd0);
        rsp_en = 1'b1;
        step();
        i_redirect_valid = 1'b0;
        #1;
        chk("rd_flushed", {31'd0, o_inst_valid}, 32'd0);
        repeat (10) step();
        drain("rd_drain");

        // Redirect coincident with a response and a decode pop.
        do_reset();
        i_imem_req_ready = 1'b1;
        step();
        step();
        rsp_en = 1'b1;
        step();
        step();
        #1;
        chk("co_head_valid", {31'd0, o_inst_valid}, 32'd1);
        chk("co_rsp_valid", {31'd0, i_imem_rsp_valid}, 32'd1);
        i_inst_ready = 1'b1;
        i_redirect_valid = 1'b1;
        i_redirect_pc = 32'h0040_0200;
        #1;
        chk("co_pc_next", o_pc_next, 32'h0040_0200);
        chk("co_pc_en", {31'd0, o_pc_en}, 32'd1);
        step();
        i_redirect_valid = 1'b0;
        #1;
        chk("co_flushed", {31'd0, o_inst_valid}, 32'd0);
        repeat (8) step();
        drain("co_drain");

        // Reset asserted with a full instruction queue.
        do_reset();
        i_imem_req_ready = 1'b1;
        rsp_en = 1'b1;
        repeat (3) step();
        #1;
        chk("rs_full_valid", {31'd0, o_inst_valid}, 32'd1);
        i_rst = 1'b1;
        #1;
        chk("rs_req_in_rst", {31'd0, o_imem_req_valid}, 32'd0);
        chk("rs_pc_en_in_rst", {31'd0, o_pc_en}, 32'd0);
        step();
        #1;
        chk("rs_inst_valid", {31'd0, o_inst_valid}, 32'd0);
        chk("rs_inst", o_inst, 32'd0);
        chk("rs_inst_pc", o_inst_pc, 32'd0);
        chk("rs_req_valid", {31'd0, o_imem_req_valid}, 32'd0);
        chk("rs_pc_en", {31'd0, o_pc_en}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rs_perf_stall", o_perf_stall_cnt, 32'd0);
        chk("rs_perf_flush", o_perf_flush_cnt, 32'd0);
`endif
        i_rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
